packed_dsp_mac: RTL and testbench

Streaming multiply-accumulate unit that packs several low-precision products into one 24x18 signed DSP multiply, then splits them back into per-lane accumulators. Two modes: INT8x2, where two signed 8-bit activations are multiplied by one signed 8-bit weight, and BIN4, where two activations are multiplied by two ±1 binary weights to give four products. It sits between the activation/weight feeders and the output requantiser in the convolution datapath. It adds valid tracking, grouped accumulation with saturation, and a parametrised DSP pipeline depth to the existing packed-multiplier scheme.

---
 rtl/packed_mac_pkg.sv | 31 +++
 rtl/dsp_mult_24x18.sv | 47 ++++
 rtl/packed_dsp_mac.sv | 169 ++++++++++++++++
 tb/tb_packed_dsp_mac.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/packed_mac_pkg.sv
// Shared constants and types for the packed multiply-accumulate datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package packed_mac_pkg;

    localparam logic MODE_INT8X2 = 1'b0;
    localparam logic MODE_BIN4   = 1'b1;

    localparam int LANES   = 4;
    localparam int INT8_FW = 16;
    localparam int BIN_FW  = 10;
    localparam int OPA_W   = 24;
    localparam int OPB_W   = 18;

    // The high field shifted up plus a negative low field can land one step
    // below the 24/18-bit signed range (e.g. a_hi=a_lo=-128), so the packed
    // operands carry one guard bit each.
    localparam int MUL_A_W = OPA_W + 1;
    localparam int MUL_B_W = OPB_W + 1;

    // Only the bits covered by lane fields are ever consumed.
    localparam int PROD_W  = LANES * BIN_FW;

    typedef struct packed {
        logic vld;
        logic first;
        logic last;
        logic mode;
    } ctrl_t;

endpackage

// File: rtl/dsp_mult_24x18.sv
// Behavioural signed multiplier shaped for one DSP slice, no enable.
// Latency: DSP_LAT cycles from operands to product (input register included).
// Backpressure: none; accepts a new operand pair every cycle.
module dsp_mult_24x18 #(
    parameter int DSP_LAT = 3,
    parameter int A_W     = 24,
    parameter int B_W     = 18,
    parameter int P_W     = A_W + B_W
) (
    input  logic                  clk,
    input  logic signed [A_W-1:0] a,
    input  logic signed [B_W-1:0] b,
    output logic signed [P_W-1:0] p
);

    logic signed [A_W-1:0] a_r;
    logic signed [B_W-1:0] b_r;
    logic signed [P_W-1:0] prod;

    // Operand registers; left without reset so they pack into the DSP input regs.
    always_ff @(posedge clk) begin
        a_r <= a;
        b_r <= b;
    end

    // Low P_W bits of the product are exact regardless of truncation.
    assign prod = a_r * b_r;

    generate
        if (DSP_LAT == 1) begin : g_lat1
            assign p = prod;
        end else begin : g_latn
            logic signed [P_W-1:0] pipe [DSP_LAT-1];

            // Product pipeline registers (M/P stages of the slice).
            always_ff @(posedge clk) begin
                pipe[0] <= prod;
                for (int i = 1; i < DSP_LAT - 1; i++) begin
                    pipe[i] <= pipe[i-1];
                end
            end

            assign p = pipe[DSP_LAT-2];
        end
    endgenerate

endmodule

// File: rtl/packed_dsp_mac.sv
// Packs INT8x2 / BIN4 products into one DSP multiply and accumulates per lane with saturation.
// Latency: out_valid DSP_LAT+1 cycles after the in_last beat.
// Backpressure: none; one beat per cycle, back-to-back groups at full rate.
module packed_dsp_mac
    import packed_mac_pkg::*;
#(
    parameter int DSP_LAT = 3,
    parameter int ACC_W   = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic               in_mode,
    input  logic [15:0]        in_act,
    input  logic [7:0]         in_wgt,
    input  logic               in_first,
    input  logic               in_last,
    output logic               out_valid,
    output logic               out_mode,
    output logic [4*ACC_W-1:0] out_acc,
    output logic               out_sat
);

    logic start_pend;
    logic grp_mode;
    logic beat_first;
    logic beat_mode;

    assign beat_first = in_first | start_pend;
    assign beat_mode  = beat_first ? in_mode : grp_mode;

    // Group-open tracking on the input side so the latched mode steers packing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_pend <= 1'b1;
            grp_mode   <= MODE_INT8X2;
        end else if (in_valid) begin
            start_pend <= in_last;
            if (beat_first) begin
                grp_mode <= in_mode;
            end
        end
    end

    logic signed [MUL_A_W-1:0] op_a, ahi_a, alo_a, sgn_hi, sgn_lo;
    logic signed [MUL_B_W-1:0] op_b, ahi_b, alo_b, w_b;
    logic signed [PROD_W-1:0]  prod;

    // Operand packing: INT8x2 packs activations into A, BIN4 packs signs into A.
    always_comb begin
        ahi_a  = {{(MUL_A_W-8){in_act[15]}}, in_act[15:8]};
        alo_a  = {{(MUL_A_W-8){in_act[7]}},  in_act[7:0]};
        ahi_b  = {{(MUL_B_W-8){in_act[15]}}, in_act[15:8]};
        alo_b  = {{(MUL_B_W-8){in_act[7]}},  in_act[7:0]};
        w_b    = {{(MUL_B_W-8){in_wgt[7]}},  in_wgt};
        sgn_hi = in_wgt[1] ? {MUL_A_W{1'b1}} : {{(MUL_A_W-1){1'b0}}, 1'b1};
        sgn_lo = in_wgt[0] ? {MUL_A_W{1'b1}} : {{(MUL_A_W-1){1'b0}}, 1'b1};
        if (beat_mode == MODE_BIN4) begin
            op_a = (sgn_hi <<< (2 * BIN_FW)) + sgn_lo;
            op_b = (ahi_b <<< BIN_FW) + alo_b;
        end else begin
            op_a = (ahi_a <<< INT8_FW) + alo_a;
            op_b = w_b;
        end
    end

    dsp_mult_24x18 #(
        .DSP_LAT (DSP_LAT),
        .A_W     (MUL_A_W),
        .B_W     (MUL_B_W),
        .P_W     (PROD_W)
    ) u_mult (
        .clk (clk),
        .a   (op_a),
        .b   (op_b),
        .p   (prod)
    );

    ctrl_t ctrl_pipe [DSP_LAT];
    ctrl_t ctrl_p;

    assign ctrl_p = ctrl_pipe[DSP_LAT-1];

    // Beat control rides alongside the multiplier so it lines up with the product.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DSP_LAT; i++) begin
                ctrl_pipe[i] <= '0;
            end
        end else begin
            ctrl_pipe[0] <= '{vld: in_valid, first: beat_first, last: in_last, mode: beat_mode};
            for (int i = 1; i < DSP_LAT; i++) begin
                ctrl_pipe[i] <= ctrl_pipe[i-1];
            end
        end
    end

    logic signed [ACC_W-1:0] lane [LANES];

    // Lane extraction: each field is signed, so add back the borrow from the field below.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane[i] = '0;
        end
        if (ctrl_p.mode == MODE_BIN4) begin
            lane[0] = {{(ACC_W-BIN_FW){prod[BIN_FW-1]}}, prod[BIN_FW-1:0]};
            for (int i = 1; i < LANES; i++) begin
                lane[i] = {{(ACC_W-BIN_FW){prod[BIN_FW*i+BIN_FW-1]}}, prod[BIN_FW*i +: BIN_FW]}
                        + {{(ACC_W-1){1'b0}}, prod[BIN_FW*i-1]};
            end
        end else begin
            lane[0] = {{(ACC_W-INT8_FW){prod[INT8_FW-1]}}, prod[INT8_FW-1:0]};
            lane[1] = {{(ACC_W-INT8_FW){prod[2*INT8_FW-1]}}, prod[2*INT8_FW-1:INT8_FW]}
                    + {{(ACC_W-1){1'b0}}, prod[INT8_FW-1]};
        end
    end

    logic signed [ACC_W-1:0] acc      [LANES];
    logic signed [ACC_W-1:0] acc_base [LANES];
    logic signed [ACC_W-1:0] acc_nxt  [LANES];
    logic signed [ACC_W:0]   acc_sum  [LANES];
    logic                    acc_sat;
    logic                    sat_nxt;

    // Saturating accumulate; a group's first beat loads instead of adding.
    always_comb begin
        sat_nxt = ctrl_p.first ? 1'b0 : acc_sat;
        for (int i = 0; i < LANES; i++) begin
            acc_base[i] = ctrl_p.first ? '0 : acc[i];
            acc_sum[i]  = {acc_base[i][ACC_W-1], acc_base[i]} + {lane[i][ACC_W-1], lane[i]};
            acc_nxt[i]  = acc_sum[i][ACC_W-1:0];
            if (acc_sum[i][ACC_W] != acc_sum[i][ACC_W-1]) begin
                sat_nxt    = 1'b1;
                acc_nxt[i] = acc_sum[i][ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                               : {1'b0, {(ACC_W-1){1'b1}}};
            end
        end
    end

    // Accumulator state and the held result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LANES; i++) begin
                acc[i] <= '0;
            end
            acc_sat   <= 1'b0;
            out_valid <= 1'b0;
            out_mode  <= 1'b0;
            out_sat   <= 1'b0;
            out_acc   <= '0;
        end else begin
            out_valid <= ctrl_p.vld & ctrl_p.last;
            if (ctrl_p.vld) begin
                for (int i = 0; i < LANES; i++) begin
                    acc[i] <= acc_nxt[i];
                end
                acc_sat <= sat_nxt;
                if (ctrl_p.last) begin
                    out_mode <= ctrl_p.mode;
                    out_sat  <= sat_nxt;
                    for (int i = 0; i < LANES; i++) begin
                        out_acc[i*ACC_W +: ACC_W] <= acc_nxt[i];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_packed_dsp_mac.sv
// Self-checking bench: directed cases plus random beats against a lane-arithmetic model.
// Latency: expects results DSP_LAT+1 = 4 cycles after each closing beat.
// Backpressure: none; drives at most one beat per cycle.
module tb_packed_dsp_mac;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_mode, in_first, in_last;
    logic [15:0] in_act;
    logic [7:0]  in_wgt;

    logic        o_vld0, o_mode0, o_sat0;
    logic [95:0] o_acc0;
    logic        o_vld1, o_mode1, o_sat1;
    logic [67:0] o_acc1;

    always #5 clk = ~clk;

    packed_dsp_mac #(.DSP_LAT(3), .ACC_W(24)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_mode(in_mode),
        .in_act(in_act), .in_wgt(in_wgt), .in_first(in_first), .in_last(in_last),
        .out_valid(o_vld0), .out_mode(o_mode0), .out_acc(o_acc0), .out_sat(o_sat0)
    );

    packed_dsp_mac #(.DSP_LAT(3), .ACC_W(17)) u_dut17 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_mode(in_mode),
        .in_act(in_act), .in_wgt(in_wgt), .in_first(in_first), .in_last(in_last),
        .out_valid(o_vld1), .out_mode(o_mode1), .out_acc(o_acc1), .out_sat(o_sat1)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic        mode;
        logic        sat;
        logic [95:0] acc;
        logic [31:0] due;
    } exp_t;

    exp_t   q0[$];
    exp_t   q1[$];
    exp_t   last0, last1;
    bit     open;
    bit     gmode;
    longint macc [2][4];
    bit     msat [2];

    // Reference: plain integer lane products, per-width clamping, group bookkeeping.
    task automatic model_beat(input logic mode, input logic [15:0] act, input logic [7:0] wgt,
                              input logic first, input logic last);
        longint p [4];
        longint ahi, alo, w, s0, s1, s, hi, lo;
        logic [95:0] mask;
        int wd;
        exp_t e;
        if (first || !open) begin
            gmode = mode;
            for (int k = 0; k < 2; k++) begin
                msat[k] = 0;
                for (int i = 0; i < 4; i++) macc[k][i] = 0;
            end
        end
        ahi = longint'($signed(act[15:8]));
        alo = longint'($signed(act[7:0]));
        w   = longint'($signed(wgt));
        if (!gmode) begin
            p[0] = alo * w; p[1] = ahi * w; p[2] = 0; p[3] = 0;
        end else begin
            s0 = wgt[0] ? -1 : 1;
            s1 = wgt[1] ? -1 : 1;
            p[0] = s0 * alo; p[1] = s0 * ahi; p[2] = s1 * alo; p[3] = s1 * ahi;
        end
        for (int k = 0; k < 2; k++) begin
            wd = (k == 0) ? 24 : 17;
            hi = (longint'(1) << (wd - 1)) - 1;
            lo = -hi - 1;
            for (int i = 0; i < 4; i++) begin
                s = macc[k][i] + p[i];
                if (s > hi) begin s = hi; msat[k] = 1; end
                else if (s < lo) begin s = lo; msat[k] = 1; end
                macc[k][i] = s;
            end
        end
        open = 1;
        if (last) begin
            for (int k = 0; k < 2; k++) begin
                wd   = (k == 0) ? 24 : 17;
                mask = (96'(1) << wd) - 96'(1);
                e.mode = gmode;
                e.sat  = msat[k];
                e.acc  = '0;
                e.due  = 32'(cyc + 4);
                for (int i = 0; i < 4; i++) e.acc = e.acc | ((96'(macc[k][i]) & mask) << (i * wd));
                if (k == 0) q0.push_back(e); else q1.push_back(e);
            end
            open = 0;
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        open  = 0;
        gmode = 0;
        last0 = '0;
        last1 = '0;
    endtask

    task automatic beat(input logic v, input logic mode, input logic [15:0] act,
                        input logic [7:0] wgt, input logic first, input logic last);
        @(negedge clk);
        in_valid = v; in_mode = mode; in_act = act; in_wgt = wgt;
        in_first = first; in_last = last;
        if (v) model_beat(mode, act, wgt, first, last);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 0; in_first = 0; in_last = 0;
        end
    endtask

    // Output monitor: every result matched in order and on time; held values between results.
    always @(negedge clk) begin
        if (reset) begin
            exp_t e;
            if (o_vld0) begin
                if (q0.size() == 0) check("spurious_vld24", o_vld0, 1'b0);
                else begin
                    e = q0.pop_front();
                    check("latency24", cyc, e.due);
                    check("acc24", o_acc0, e.acc);
                    check("mode_sat24", {o_mode0, o_sat0}, {e.mode, e.sat});
                    last0 = e;
                end
            end else check("hold24", {o_mode0, o_sat0, o_acc0}, {last0.mode, last0.sat, last0.acc});
            if (o_vld1) begin
                if (q1.size() == 0) check("spurious_vld17", o_vld1, 1'b0);
                else begin
                    e = q1.pop_front();
                    check("latency17", cyc, e.due);
                    check("acc17", o_acc1, e.acc);
                    check("mode_sat17", {o_mode1, o_sat1}, {e.mode, e.sat});
                    last1 = e;
                end
            end else check("hold17", {o_mode1, o_sat1, o_acc1}, {last1.mode, last1.sat, last1.acc[67:0]});
        end
    end

    initial begin
        reset = 0; in_valid = 0; in_mode = 0; in_act = '0; in_wgt = '0; in_first = 0; in_last = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_outs24", {o_vld0, o_mode0, o_sat0, o_acc0}, '0);
        check("rst_outs17", {o_vld1, o_mode1, o_sat1, o_acc1}, '0);
        @(negedge clk);
        reset = 1;

        // INT8x2 single and two-beat groups
        beat(1, 0, 16'hFC40, 8'hFC, 1, 1); idle(6);
        beat(1, 0, 16'hFC40, 8'hFC, 1, 0);
        beat(1, 0, 16'hFC01, 8'h0C, 0, 1);
        beat(1, 0, 16'h98F3, 8'h55, 1, 1);
        // BIN4 single beats, back to back
        beat(1, 1, 16'hFC01, 8'h01, 1, 1);
        beat(1, 1, 16'hFC40, 8'h02, 1, 1);
        beat(1, 1, 16'hFC01, 8'h03, 1, 1);
        // saturation on the narrow instance, then a clean implicit-start group
        beat(1, 0, 16'h8080, 8'h80, 1, 0);
        beat(1, 0, 16'h8080, 8'h80, 0, 0);
        beat(1, 0, 16'h8080, 8'h80, 0, 0);
        beat(1, 0, 16'h8080, 8'h80, 0, 1);
        beat(1, 0, 16'h0101, 8'h01, 0, 1);
        // mode latch across a bubble
        beat(1, 1, 16'h1234, 8'h02, 1, 0); idle(1);
        beat(1, 0, 16'h7F80, 8'h01, 0, 1);
        // in_first mid-group discards the open group
        beat(1, 0, 16'h0505, 8'h05, 1, 0);
        beat(1, 1, 16'h0303, 8'h01, 1, 1);
        // flags on an invalid cycle are ignored
        beat(0, 1, 16'hFFFF, 8'hFF, 1, 1);
        beat(1, 0, 16'h0202, 8'h03, 0, 0);
        beat(1, 0, 16'h0101, 8'h01, 0, 1);
        idle(8);

        // reset with two beats in flight
        beat(1, 0, 16'h1111, 8'h11, 1, 0);
        beat(1, 0, 16'h2222, 8'h22, 0, 1);
        @(negedge clk);
        in_valid = 0; in_first = 0; in_last = 0;
        #2 reset = 0;
        model_reset();
        #1;
        check("async_rst24", {o_vld0, o_mode0, o_sat0, o_acc0}, '0);
        check("async_rst17", {o_vld1, o_mode1, o_sat1, o_acc1}, '0);
        repeat (2) @(negedge clk);
        reset = 1;
        idle(6);
        beat(1, 1, 16'h0403, 8'h02, 0, 1);
        idle(8);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            beat(($urandom % 4) != 0, $urandom % 2, 16'($urandom), 8'($urandom),
                 ($urandom % 8) == 0, ($urandom % 3) == 0);
        end
        idle(12);
        check("drain24", q0.size(), 0);
        check("drain17", q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
